// File: rtl/priv_trap_ctrl.sv
// Trap sequencer: prioritises sync exceptions, interrupts and xRET/WFI,
// drains the pipeline, then emits a one-cycle redirect and CSR-update strobe.
module priv_trap_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CAUSE_W = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               fault_insn,
  input  logic               mal_insn,
  input  logic               illegal_insn,
  input  logic               fault_l,
  input  logic               mal_l,
  input  logic               fault_s,
  input  logic               mal_s,
  input  logic               breakpoint,
  input  logic               env,
  input  logic               fault_insn_page,
  input  logic               fault_load_page,
  input  logic               fault_store_page,
  input  logic               prot_fault_i,
  input  logic               prot_fault_l,
  input  logic               prot_fault_s,
  input  logic               mret,
  input  logic               sret,
  input  logic               wfi,
  input  logic [XLEN-1:0]    epc,
  input  logic [XLEN-1:0]    badaddr,
  input  logic               pipe_clear,
  input  logic               timer_int,
  input  logic               soft_int,
  input  logic               ext_int,
  input  logic               mie_t,
  input  logic               mie_s,
  input  logic               mie_e,
  input  logic               mstatus_mie,
  input  logic [1:0]         curr_privilege_level,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    mepc,
  input  logic [XLEN-1:0]    sepc,
  output logic               intr,
  output logic               insert_pc,
  output logic [XLEN-1:0]    priv_pc,
  output logic               trap_valid,
  output logic [CAUSE_W-1:0] trap_cause,
  output logic               trap_is_int,
  output logic [XLEN-1:0]    trap_epc,
  output logic [XLEN-1:0]    trap_tval,
  output logic               mret_commit,
  output logic               sret_commit,
  output logic               wfi_sleep
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, SLEEP} state_t;
  typedef enum logic [1:0] {K_TRAP, K_MRET, K_SRET} kind_t;

  // Causes whose tval carries the faulting address: 0,1,4-7,12,13,15
  localparam logic [15:0] TVAL_MASK = 16'b1011_0000_1111_0011;

  state_t             state, state_nx;
  kind_t              kind_q, ld_kind;
  logic [CAUSE_W-1:0] cause_q, ld_cause;
  logic               is_int_q, ld_int;
  logic [XLEN-1:0]    epc_q, tval_q, target_q;
  logic [XLEN-1:0]    ld_tval, ld_target;
  logic               ld;

  logic               exc_hit;
  logic [CAUSE_W-1:0] exc_code, env_code, int_code;
  logic [2:0]         int_pend;
  logic               int_any, int_en;

  // Synchronous exception priority encoder
  always_comb begin
    case (curr_privilege_level)
      2'd0:    env_code = CAUSE_W'(8);
      2'd1:    env_code = CAUSE_W'(9);
      default: env_code = CAUSE_W'(11);
    endcase
    exc_hit  = 1'b1;
    exc_code = '0;
    if      (fault_insn_page)             exc_code = CAUSE_W'(12);
    else if (fault_insn | prot_fault_i)   exc_code = CAUSE_W'(1);
    else if (illegal_insn)                exc_code = CAUSE_W'(2);
    else if (mal_insn)                    exc_code = CAUSE_W'(0);
    else if (env)                         exc_code = env_code;
    else if (breakpoint)                  exc_code = CAUSE_W'(3);
    else if (mal_s)                       exc_code = CAUSE_W'(6);
    else if (mal_l)                       exc_code = CAUSE_W'(4);
    else if (fault_store_page)            exc_code = CAUSE_W'(15);
    else if (fault_load_page)             exc_code = CAUSE_W'(13);
    else if (fault_s | prot_fault_s)      exc_code = CAUSE_W'(7);
    else if (fault_l | prot_fault_l)      exc_code = CAUSE_W'(5);
    else                                  exc_hit  = 1'b0;
  end

  // Interrupt qualification and priority (ext > soft > timer)
  always_comb begin
    int_pend = {ext_int & mie_e, soft_int & mie_s, timer_int & mie_t};
    int_any  = |int_pend;
    int_en   = mstatus_mie || (curr_privilege_level != 2'd3);
    if      (int_pend[2]) int_code = CAUSE_W'(11);
    else if (int_pend[1]) int_code = CAUSE_W'(3);
    else                  int_code = CAUSE_W'(7);
  end

  // Next-state selection and the values latched on event acceptance
  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    ld_kind  = K_TRAP;
    ld_cause = exc_code;
    ld_int   = 1'b0;
    case (state)
      IDLE: begin
        if (exc_hit) begin
          ld = 1'b1; state_nx = DRAIN;
        end else if (int_any && int_en) begin
          ld = 1'b1; ld_int = 1'b1; ld_cause = int_code; state_nx = DRAIN;
        end else if (mret) begin
          ld = 1'b1; ld_kind = K_MRET; ld_cause = '0; state_nx = DRAIN;
        end else if (sret) begin
          ld = 1'b1; ld_kind = K_SRET; ld_cause = '0; state_nx = DRAIN;
        end else if (wfi) begin
          state_nx = SLEEP;
        end
      end
      DRAIN:  if (pipe_clear) state_nx = COMMIT;
      COMMIT: state_nx = IDLE;
      SLEEP: begin
        // Wake on any enabled pending source; only a takeable one traps
        if (int_any) begin
          if (int_en) begin
            ld = 1'b1; ld_int = 1'b1; ld_cause = int_code; state_nx = DRAIN;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    ld_tval = '0;
    if (ld_kind == K_TRAP && !ld_int && ld_cause < CAUSE_W'(16) && TVAL_MASK[ld_cause[3:0]])
      ld_tval = badaddr;

    case (ld_kind)
      K_MRET:  ld_target = mepc;
      K_SRET:  ld_target = sepc;
      default: ld_target = {mtvec[XLEN-1:2], 2'b00} +
                           ((ld_int && mtvec[1:0] == 2'd1) ? (XLEN'(ld_cause) << 2) : '0);
    endcase
  end

  // State register and latched trap context
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      kind_q   <= K_TRAP;
      cause_q  <= '0;
      is_int_q <= 1'b0;
      epc_q    <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state <= state_nx;
      if (ld) begin
        kind_q   <= ld_kind;
        cause_q  <= ld_cause;
        is_int_q <= ld_int;
        epc_q    <= epc;
        tval_q   <= ld_tval;
        target_q <= ld_target;
      end
    end
  end

  // Outputs decoded from state; trap fields are only driven with trap_valid
  always_comb begin
    intr        = (state == DRAIN) || (state == COMMIT);
    insert_pc   = (state == COMMIT);
    priv_pc     = insert_pc ? target_q : '0;
    trap_valid  = insert_pc && (kind_q == K_TRAP);
    trap_cause  = trap_valid ? cause_q : '0;
    trap_is_int = trap_valid && is_int_q;
    trap_epc    = trap_valid ? epc_q : '0;
    trap_tval   = trap_valid ? tval_q : '0;
    mret_commit = insert_pc && (kind_q == K_MRET);
    sret_commit = insert_pc && (kind_q == K_SRET);
    wfi_sleep   = (state == SLEEP);
  end

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Scoreboarded bench for priv_trap_ctrl: stimulus pushes expected redirects,
// a negedge monitor pops and compares whenever insert_pc is presented.
module tb_priv_trap_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s;
  logic        breakpoint, env, fault_insn_page, fault_load_page, fault_store_page;
  logic        prot_fault_i, prot_fault_l, prot_fault_s;
  logic        mret, sret, wfi;
  logic [31:0] epc, badaddr;
  logic        pipe_clear;
  logic        timer_int, soft_int, ext_int, mie_t, mie_s, mie_e, mstatus_mie;
  logic [1:0]  curr_privilege_level;
  logic [31:0] mtvec, mepc, sepc;
  logic        intr, insert_pc, trap_valid, trap_is_int, mret_commit, sret_commit, wfi_sleep;
  logic [31:0] priv_pc, trap_epc, trap_tval;
  logic [4:0]  trap_cause;

  priv_trap_ctrl #(.XLEN(32), .CAUSE_W(5)) dut (
    .CLK(CLK), .RST(RST),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .fault_l(fault_l), .mal_l(mal_l), .fault_s(fault_s), .mal_s(mal_s),
    .breakpoint(breakpoint), .env(env), .fault_insn_page(fault_insn_page),
    .fault_load_page(fault_load_page), .fault_store_page(fault_store_page),
    .prot_fault_i(prot_fault_i), .prot_fault_l(prot_fault_l), .prot_fault_s(prot_fault_s),
    .mret(mret), .sret(sret), .wfi(wfi), .epc(epc), .badaddr(badaddr),
    .pipe_clear(pipe_clear), .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
    .mie_t(mie_t), .mie_s(mie_s), .mie_e(mie_e), .mstatus_mie(mstatus_mie),
    .curr_privilege_level(curr_privilege_level), .mtvec(mtvec), .mepc(mepc), .sepc(sepc),
    .intr(intr), .insert_pc(insert_pc), .priv_pc(priv_pc), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .trap_is_int(trap_is_int), .trap_epc(trap_epc),
    .trap_tval(trap_tval), .mret_commit(mret_commit), .sret_commit(sret_commit),
    .wfi_sleep(wfi_sleep)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic        tv;
    logic [4:0]  cause;
    logic        is_int;
    logic [31:0] epc;
    logic [31:0] tval;
    logic        mr;
    logic        sr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chk(name, {31'b0, act}, {31'b0, req});
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic tv, input logic [4:0] cause,
                              input logic is_int, input logic [31:0] e, input logic [31:0] tval,
                              input logic mr, input logic sr);
    exp_t x;
    x.pc = pc; x.tv = tv; x.cause = cause; x.is_int = is_int;
    x.epc = e; x.tval = tval; x.mr = mr; x.sr = sr;
    return x;
  endfunction

  // Monitor: compares every presented redirect against the scoreboard head
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (insert_pc === 1'b1) begin
        if (sb.size() == 0) begin
          chk1("unexpected_redirect", insert_pc, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("priv_pc", priv_pc, e.pc);
          chk1("trap_valid", trap_valid, e.tv);
          chk("trap_cause", {27'b0, trap_cause}, {27'b0, e.cause});
          chk1("trap_is_int", trap_is_int, e.is_int);
          chk("trap_epc", trap_epc, e.epc);
          chk("trap_tval", trap_tval, e.tval);
          chk1("mret_commit", mret_commit, e.mr);
          chk1("sret_commit", sret_commit, e.sr);
        end
      end else if ((trap_valid | mret_commit | sret_commit) === 1'b1) begin
        chk("stray_strobe", {29'b0, trap_valid, mret_commit, sret_commit}, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ev();
    fault_insn = 0; mal_insn = 0; illegal_insn = 0; fault_l = 0; mal_l = 0;
    fault_s = 0; mal_s = 0; breakpoint = 0; env = 0; fault_insn_page = 0;
    fault_load_page = 0; fault_store_page = 0; prot_fault_i = 0; prot_fault_l = 0;
    prot_fault_s = 0; mret = 0; sret = 0; wfi = 0;
    timer_int = 0; soft_int = 0; ext_int = 0;
  endtask

  // Event inputs are already driven; pipe_clear is high, so redirect lands 2 edges later
  task automatic run_event(input exp_t e);
    sb.push_back(e);
    tick();
    chk1("intr_drain", intr, 1'b1);
    chk1("insert_early", insert_pc, 1'b0);
    clear_ev();
    tick();
    chk1("insert_latency", insert_pc, 1'b1);
    chk1("intr_commit", intr, 1'b1);
    tick();
    chk1("intr_idle", intr, 1'b0);
    chk1("insert_drop", insert_pc, 1'b0);
  endtask

  initial begin : stim
    clear_ev();
    RST = 1; pipe_clear = 1; epc = 0; badaddr = 0;
    mie_t = 0; mie_s = 0; mie_e = 0; mstatus_mie = 0;
    curr_privilege_level = 2'd3; mtvec = 0; mepc = 0; sepc = 0;
    tick(); tick();
    chk1("rst_intr", intr, 1'b0);
    chk1("rst_insert", insert_pc, 1'b0);
    chk1("rst_trap_valid", trap_valid, 1'b0);
    chk1("rst_wfi_sleep", wfi_sleep, 1'b0);
    chk("rst_priv_pc", priv_pc, 32'h0);
    RST = 0;
    tick();

    // Illegal instruction, direct mode
    epc = 32'h100; mtvec = 32'h200; illegal_insn = 1;
    run_event(mk(32'h200, 1, 5'd2, 0, 32'h100, 32'h0, 0, 0));

    // Instruction page fault outranks load misalign
    epc = 32'h104; badaddr = 32'h8000_0004; fault_insn_page = 1; mal_l = 1;
    run_event(mk(32'h200, 1, 5'd12, 0, 32'h104, 32'h8000_0004, 0, 0));

    // Vectored timer interrupt
    mtvec = 32'h301; mstatus_mie = 1; mie_t = 1; timer_int = 1; epc = 32'h108;
    run_event(mk(32'h31C, 1, 5'd7, 1, 32'h108, 32'h0, 0, 0));

    // External outranks timer
    mie_e = 1; ext_int = 1; timer_int = 1; epc = 32'h10C;
    run_event(mk(32'h32C, 1, 5'd11, 1, 32'h10C, 32'h0, 0, 0));

    // Sync exception outranks interrupt; exceptions are not vectored
    badaddr = 32'h1233; mal_s = 1; timer_int = 1; epc = 32'h110;
    run_event(mk(32'h300, 1, 5'd6, 0, 32'h110, 32'h1233, 0, 0));

    // ECALL from S: tval is zero even with badaddr set
    mstatus_mie = 0; curr_privilege_level = 2'd1; env = 1; epc = 32'h114;
    run_event(mk(32'h300, 1, 5'd9, 0, 32'h114, 32'h0, 0, 0));

    // PMP load fault folds into cause 5
    curr_privilege_level = 2'd3; prot_fault_l = 1; epc = 32'h118;
    run_event(mk(32'h300, 1, 5'd5, 0, 32'h118, 32'h1233, 0, 0));

    // Interrupt taken in U even with mstatus_mie=0
    curr_privilege_level = 2'd0; mie_s = 1; soft_int = 1; epc = 32'h11C;
    run_event(mk(32'h30C, 1, 5'd3, 1, 32'h11C, 32'h0, 0, 0));
    curr_privilege_level = 2'd3;

    // Vectored target wraps modulo 2^32
    mstatus_mie = 1; mtvec = 32'hFFFF_FFFD; ext_int = 1; epc = 32'h120;
    run_event(mk(32'h28, 1, 5'd11, 1, 32'h120, 32'h0, 0, 0));

    // mret with pipeline held busy; new events during drain are ignored
    mstatus_mie = 0; mtvec = 32'h200; mepc = 32'h4000; mret = 1;
    sb.push_back(mk(32'h4000, 0, 5'd0, 0, 32'h0, 32'h0, 1, 0));
    tick();
    clear_ev();
    pipe_clear = 0; illegal_insn = 1;
    for (int i = 0; i < 3; i++) begin
      chk1("mret_intr_hold", intr, 1'b1);
      chk1("mret_no_insert", insert_pc, 1'b0);
      tick();
    end
    pipe_clear = 1; illegal_insn = 0;
    tick();
    chk1("mret_insert", insert_pc, 1'b1);
    tick();
    chk1("mret_idle", intr, 1'b0);

    // mret beats sret; then sret alone
    sepc = 32'h5008; mret = 1; sret = 1;
    run_event(mk(32'h4000, 0, 5'd0, 0, 32'h0, 32'h0, 1, 0));
    sret = 1;
    run_event(mk(32'h5008, 0, 5'd0, 0, 32'h0, 32'h0, 0, 1));

    // WFI woken by untakeable interrupt: resume without redirect
    mie_s = 1; mstatus_mie = 0; wfi = 1;
    tick();
    chk1("wfi_sleep", wfi_sleep, 1'b1);
    chk1("wfi_intr", intr, 1'b0);
    clear_ev();
    illegal_insn = 1;
    tick();
    chk1("sleep_ignores_exc", wfi_sleep, 1'b1);
    illegal_insn = 0; soft_int = 1;
    tick();
    chk1("wake_sleep_drop", wfi_sleep, 1'b0);
    chk1("wake_no_intr", intr, 1'b0);
    soft_int = 0;
    tick(); tick();
    chk1("wake_still_idle", intr, 1'b0);

    // WFI woken by takeable interrupt: trap
    mstatus_mie = 1; wfi = 1;
    tick();
    chk1("wfi_sleep2", wfi_sleep, 1'b1);
    clear_ev();
    soft_int = 1; epc = 32'h130;
    sb.push_back(mk(32'h200, 1, 5'd3, 1, 32'h130, 32'h0, 0, 0));
    tick();
    chk1("wake_drain_intr", intr, 1'b1);
    chk1("wake_drain_sleep", wfi_sleep, 1'b0);
    clear_ev();
    tick();
    chk1("wake_insert", insert_pc, 1'b1);
    tick();
    chk1("wake_idle", intr, 1'b0);

    // Reset during DRAIN aborts the trap
    mstatus_mie = 0; illegal_insn = 1; pipe_clear = 0;
    tick();
    chk1("abort_drain", intr, 1'b1);
    clear_ev();
    RST = 1;
    tick();
    chk1("abort_intr", intr, 1'b0);
    chk1("abort_insert", insert_pc, 1'b0);
    RST = 0; pipe_clear = 1;
    repeat (3) tick();
    chk1("abort_idle", intr, 1'b0);

    repeat (2) tick();
    chk("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priv_trap_ctrl.md
Name: priv_trap_ctrl

Overview:
Trap sequencer between the pipeline/hazard unit and the privilege CSR file. Each cycle it prioritises synchronous exceptions, protection faults, enabled interrupts and xRET/WFI requests. It holds the pipeline in a drain handshake until the pipeline is clear, then emits a one-cycle PC redirect plus a CSR-update strobe carrying cause, EPC and tval. It produces priv_pc/insert_pc/intr for the hazard unit.

Parameters:
XLEN, 32, datapath width for PCs, addresses and CSR values
CAUSE_W, 5, width of the exception/interrupt code

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s  in  1 each  sync exception flags (mem stage)
breakpoint, env, fault_insn_page, fault_load_page, fault_store_page  in  1 each  sync exception flags
prot_fault_i, prot_fault_l, prot_fault_s  in  1 each  PMP/PMA faults; OR'd into fault_insn/fault_l/fault_s
mret, sret, wfi  in  1 each  instruction requests
epc  in  XLEN  PC of faulting/retiring instruction
badaddr  in  XLEN  faulting address
pipe_clear  in  1  pipeline drained
timer_int, soft_int, ext_int  in  1 each  pending interrupt lines (mip)
mie_t, mie_s, mie_e  in  1 each  per-source enables (mie)
mstatus_mie  in  1  global interrupt enable
curr_privilege_level  in  2  0=U, 1=S, 3=M
mtvec, mepc, sepc  in  XLEN  CSR values
intr  out  1  trap/xret pending; hazard unit flushes
insert_pc  out  1  one-cycle redirect strobe
priv_pc  out  XLEN  redirect target, valid with insert_pc
trap_valid  out  1  one-cycle CSR trap-entry strobe
trap_cause  out  CAUSE_W  cause code
trap_is_int  out  1  mcause interrupt bit
trap_epc  out  XLEN  value for mepc
trap_tval  out  XLEN  value for mtval
mret_commit, sret_commit  out  1 each  one-cycle xRET strobes
wfi_sleep  out  1  high while in SLEEP

Behaviour:
- Reset: state=IDLE; all outputs 0; latched cause/epc/tval/target = 0. RST in any state returns to IDLE the next edge and aborts the pending trap; no strobe is emitted.
- States: IDLE, DRAIN, COMMIT, SLEEP.
- Exception priority, highest first, with cause code:
  - fault_insn_page 12; fault_insn/prot_fault_i 1; illegal_insn 2; mal_insn 0.
  - env: 8 in U, 9 in S, 11 in M.
  - breakpoint 3; mal_s 6; mal_l 4; fault_store_page 15; fault_load_page 13.
  - fault_s/prot_fault_s 7; fault_l/prot_fault_l 5.
- Interrupt is taken only if mstatus_mie=1 or privilege<M, and the source is pending AND enabled. Interrupt priority: ext 11 > soft 3 > timer 7.
- Same-cycle precedence: sync exception > interrupt > mret > sret > wfi.
- IDLE, event detected in cycle N: latch cause, is_int, epc, and tval (badaddr for cause 0/1/4-7/12/13/15, else 0). Target:
  - trap: (mtvec & ~3), plus 4*cause if is_int and mtvec[1:0]==1.
  - mret: mepc; sret: sepc.
  - Go to DRAIN; intr=1 from cycle N+1.
- IDLE with wfi and no other event: go to SLEEP; wfi_sleep=1.
- DRAIN: intr=1. When pipe_clear=1, go to COMMIT the next cycle. New events in DRAIN are ignored.
- COMMIT (exactly 1 cycle): insert_pc=1, priv_pc=target, intr=1.
  - trap: trap_valid=1 with trap_cause/trap_is_int/trap_epc/trap_tval.
  - mret/sret: the matching *_commit=1; trap_valid=0.
  - Then return to IDLE; all strobes drop the next cycle.
- Minimum latency is detection -> insert_pc = 2 cycles when pipe_clear is already high.
- SLEEP: leave when any source is pending & enabled, regardless of mstatus_mie.
  - If the interrupt is takeable: latch it and go to DRAIN.
  - Otherwise: return to IDLE with no redirect (resume at next PC).
  - Sync exceptions are not sampled while in SLEEP.
- The trap target computation wraps modulo 2^XLEN.

Test Plan:
- illegal_insn=1, epc=0x100, mtvec=0x200, pipe_clear=1 -> two cycles later insert_pc=1, priv_pc=0x200, trap_valid=1, cause=2, trap_is_int=0, tval=0.
- Same cycle fault_insn_page=1 and mal_l=1, badaddr=0x8000_0004 -> cause=12, tval=0x8000_0004.
- timer_int=1, mie_t=1, mstatus_mie=1, mtvec=0x301 -> priv_pc=0x31C, trap_is_int=1, cause=7; ext_int raised the same cycle -> cause=11, priv_pc=0x32C.
- mret with mepc=0x4000 and pipe_clear held low for 3 cycles -> intr stays 1 throughout; insert_pc pulses once 1 cycle after pipe_clear rises, priv_pc=0x4000, mret_commit=1, trap_valid=0.
- wfi, then soft_int=1 with mie_s=1, mstatus_mie=0, priv=M -> wfi_sleep 1 then 0, return to IDLE, no insert_pc. Repeat with mstatus_mie=1 -> trap with cause=3.
- RST asserted during DRAIN -> next cycle intr=0, no insert_pc/trap_valid is ever emitted, state IDLE.
